// File: rtl/lc3b_types.sv
// Shared types for the physical-memory scheduler.
// Word, line and scheduler state types.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    DONE    = 2'd3
  } pmem_state_e;

  function automatic logic is_grant(pmem_state_e s);
    return (s == GRANT_I) || (s == GRANT_D);
  endfunction

endpackage

// File: rtl/pmem_sched.sv
// pmem_sched: arbitrates icache/dcache line traffic onto one physical
// memory port. FSM IDLE -> GRANT_I/GRANT_D -> DONE -> IDLE.
// Ports:
//   clk, reset_n            clock, async active-low reset
//   icache_pmem_*           icache line-fill request / response
//   dcache_pmem_*           dcache fill / write-back request / response
//   pmem_*                  physical memory command and completion
//   ld_regs                 pipeline-latch advance enable
// Macro PMEM_SCHED_STARVE_EN: dcache-streak limit protecting icache.
module pmem_sched
  import lc3b_types::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         icache_pmem_read,
  input  logic [15:0]  icache_pmem_address,
  input  logic         dcache_pmem_read,
  input  logic         dcache_pmem_write,
  input  logic [15:0]  dcache_pmem_address,
  input  logic [127:0] dcache_pmem_wdata,
  input  logic         pmem_resp,
  input  logic [127:0] pmem_rdata,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  output logic         icache_pmem_resp,
  output logic         dcache_pmem_resp,
  output logic [127:0] icache_pmem_rdata,
  output logic [127:0] dcache_pmem_rdata,
  output logic         ld_regs
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_bad_limit
    $error("pmem_sched: STARVE_LIMIT must be 1..7");
  end

  pmem_state_e state_q, state_d;
  lc3b_word    addr_q, addr_d;
  lc3b_line    wdata_q, wdata_d;
  logic        wr_q, wr_d;

  logic i_req;
  logic d_req;
  logic starve;
  logic take_d;
  logic take_i;

  assign i_req = icache_pmem_read;
  assign d_req = dcache_pmem_read | dcache_pmem_write;

`ifdef PMEM_SCHED_STARVE_EN
  logic [2:0] starve_q, starve_d;

  // Only meaningful while icache is actually waiting.
  assign starve = i_req &&
                  (starve_q == 3'(STARVE_LIMIT));
`else
  assign starve = 1'b0;
`endif

  assign take_d = (state_q == IDLE) && d_req && !starve;
  assign take_i = (state_q == IDLE) && !take_d && i_req;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          take_d: begin
            state_d = GRANT_D;
            addr_d  = dcache_pmem_address;
            wdata_d = dcache_pmem_wdata;
            // read+write together is a write-back
            wr_d    = dcache_pmem_write;
          end
          take_i: begin
            state_d = GRANT_I;
            addr_d  = icache_pmem_address;
            wdata_d = '0;
            wr_d    = 1'b0;
          end
          default: state_d = IDLE;
        endcase
      end
      GRANT_I, GRANT_D: begin
        if (pmem_resp) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
    end
  end

`ifdef PMEM_SCHED_STARVE_EN
  always_comb begin
    starve_d = starve_q;
    if (take_i) begin
      starve_d = '0;
    end else if (take_d && i_req &&
                 starve_q != 3'd7) begin
      starve_d = starve_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) starve_q <= '0;
    else          starve_q <= starve_d;
  end
`endif

  assign pmem_read    = is_grant(state_q) && !wr_q;
  assign pmem_write   = is_grant(state_q) && wr_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

  // A cache that withdrew its request mid-grant gets no resp.
  assign icache_pmem_resp = (state_q == GRANT_I) &&
                            pmem_resp && i_req;
  assign dcache_pmem_resp = (state_q == GRANT_D) &&
                            pmem_resp && d_req;

  // Data path is unregistered; gated so reset forces all outputs low.
  assign icache_pmem_rdata = reset_n ? pmem_rdata : '0;
  assign dcache_pmem_rdata = reset_n ? pmem_rdata : '0;

  assign ld_regs = reset_n && !is_grant(state_q) &&
                   !i_req && !d_req;

endmodule

// File: tb/tb_pmem_sched.sv
// Testbench for pmem_sched: directed vector table, corner sequences
// and randomized traffic against a transaction-level model.
module tb_pmem_sched;

  localparam int LIM = 2;
  localparam logic [127:0] W = {16{8'hA5}};
  localparam logic [127:0] R =
    128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         i_rd;
  logic [15:0]  i_ad;
  logic         d_rd;
  logic         d_wr;
  logic [15:0]  d_ad;
  logic [127:0] d_wd;
  logic         p_resp;
  logic [127:0] p_rdata;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         ic_resp;
  logic         dc_resp;
  logic [127:0] ic_rdata;
  logic [127:0] dc_rdata;
  logic         ld_regs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pmem_sched #(.STARVE_LIMIT(LIM)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .icache_pmem_read    (i_rd),
    .icache_pmem_address (i_ad),
    .dcache_pmem_read    (d_rd),
    .dcache_pmem_write   (d_wr),
    .dcache_pmem_address (d_ad),
    .dcache_pmem_wdata   (d_wd),
    .pmem_resp           (p_resp),
    .pmem_rdata          (p_rdata),
    .pmem_read           (pmem_read),
    .pmem_write          (pmem_write),
    .pmem_address        (pmem_address),
    .pmem_wdata          (pmem_wdata),
    .icache_pmem_resp    (ic_resp),
    .dcache_pmem_resp    (dc_resp),
    .icache_pmem_rdata   (ic_rdata),
    .dcache_pmem_rdata   (dc_rdata),
    .ld_regs             (ld_regs)
  );

  task automatic chk1(string nm, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%b exp=%b", nm, act, exp);
    end
  endtask

  task automatic chk16(string nm, logic [15:0] act,
                       logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic chk128(string nm, logic [127:0] act,
                        logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        ir;
    logic [15:0] ia;
    logic        dr;
    logic        dw;
    logic [15:0] da;
    logic        pr;
    logic        erd;
    logic        ewr;
    logic [15:0] eaddr;
    logic [127:0] ewd;
    logic        eir;
    logic        edr;
    logic        eld;
  } vec_t;

  localparam int NV = 29;
  vec_t vt [NV];

  function automatic vec_t mk(
    logic ir, logic [15:0] ia, logic dr, logic dw,
    logic [15:0] da, logic pr, logic erd, logic ewr,
    logic [15:0] eaddr, logic ewd, logic eir,
    logic edr, logic eld);
    vec_t v;
    v.ir = ir;   v.ia = ia;   v.dr = dr;  v.dw = dw;
    v.da = da;   v.pr = pr;   v.erd = erd;
    v.ewr = ewr; v.eaddr = eaddr;
    v.ewd = ewd ? W : '0;
    v.eir = eir; v.edr = edr; v.eld = eld;
    return v;
  endfunction

  task automatic fill_table();
    // icache read 0x1230, resp on third grant cycle
    vt[0]  = mk(0,'h0000,0,0,'h0000,0, 0,0,'h0000,0,0,0,1);
    vt[1]  = mk(1,'h1230,0,0,'h0000,0, 0,0,'h0000,0,0,0,0);
    vt[2]  = mk(1,'h1230,0,0,'h0000,0, 1,0,'h1230,0,0,0,0);
    vt[3]  = mk(1,'h1230,0,0,'h0000,0, 1,0,'h1230,0,0,0,0);
    vt[4]  = mk(1,'h1230,0,0,'h0000,1, 1,0,'h1230,0,1,0,0);
    vt[5]  = mk(0,'h1230,0,0,'h0000,0, 0,0,'h1230,0,0,0,1);
    vt[6]  = mk(0,'h1230,0,0,'h0000,0, 0,0,'h1230,0,0,0,1);
    // simultaneous reads: dcache first, icache after DONE
    vt[7]  = mk(1,'h1111,1,0,'h2222,0, 0,0,'h1230,0,0,0,0);
    vt[8]  = mk(1,'h1111,1,0,'h2222,0, 1,0,'h2222,1,0,0,0);
    vt[9]  = mk(1,'h1111,1,0,'h2222,1, 1,0,'h2222,1,0,1,0);
    vt[10] = mk(1,'h1111,0,0,'h2222,0, 0,0,'h2222,1,0,0,0);
    vt[11] = mk(1,'h1111,0,0,'h2222,0, 0,0,'h2222,1,0,0,0);
    vt[12] = mk(1,'h1111,0,0,'h2222,0, 1,0,'h1111,0,0,0,0);
    vt[13] = mk(1,'h1111,0,0,'h2222,1, 1,0,'h1111,0,1,0,0);
    vt[14] = mk(0,'h1111,0,0,'h2222,0, 0,0,'h1111,0,0,0,1);
    // dcache write-back 0x8000
    vt[15] = mk(0,'h0000,0,1,'h8000,0, 0,0,'h1111,0,0,0,0);
    vt[16] = mk(0,'h0000,0,1,'h8000,0, 0,1,'h8000,1,0,0,0);
    vt[17] = mk(0,'h0000,0,1,'h8000,1, 0,1,'h8000,1,0,1,0);
    vt[18] = mk(0,'h0000,0,0,'h8000,0, 0,0,'h8000,1,0,0,1);
    // read and write together resolve as write
    vt[19] = mk(0,'h0000,1,1,'h4444,0, 0,0,'h8000,1,0,0,0);
    vt[20] = mk(0,'h0000,1,1,'h4444,0, 0,1,'h4444,1,0,0,0);
    vt[21] = mk(0,'h0000,1,1,'h4444,1, 0,1,'h4444,1,0,1,0);
    vt[22] = mk(0,'h0000,0,0,'h4444,0, 0,0,'h4444,1,0,0,1);
    // icache drops mid-grant: completes, resp suppressed
    vt[23] = mk(1,'h5550,0,0,'h0000,0, 0,0,'h4444,1,0,0,0);
    vt[24] = mk(1,'h5550,0,0,'h0000,0, 1,0,'h5550,0,0,0,0);
    vt[25] = mk(0,'h5550,0,0,'h0000,0, 1,0,'h5550,0,0,0,0);
    vt[26] = mk(0,'h5550,0,0,'h0000,1, 1,0,'h5550,0,0,0,0);
    vt[27] = mk(0,'h5550,0,0,'h0000,0, 0,0,'h5550,0,0,0,1);
    vt[28] = mk(0,'h5550,0,0,'h0000,0, 0,0,'h5550,0,0,0,1);
  endtask

  // ---------------- reference model ----------------
  // owner: 0 none, 1 icache, 2 dcache. cool: one turnaround cycle
  // after a completion. streak: dcache wins while icache waited.
  int           m_own;
  bit           m_cool;
  int           m_streak;
  logic [15:0]  m_addr;
  logic         m_wr;
  logic [127:0] m_wd;

  task automatic m_clear();
    m_own = 0; m_cool = 0; m_streak = 0;
    m_addr = '0; m_wr = 0; m_wd = '0;
  endtask

  task automatic m_step();
    bit ir;
    bit dq;
    bit starved;
    ir = i_rd;
    dq = d_rd | d_wr;
    starved = 0;
`ifdef PMEM_SCHED_STARVE_EN
    starved = ir && (m_streak == LIM);
`endif
    if (m_own != 0) begin
      if (p_resp) begin
        m_own = 0;
        m_cool = 1;
      end
    end else if (m_cool) begin
      m_cool = 0;
    end else if (dq && !starved) begin
      m_own = 2; m_addr = d_ad; m_wr = d_wr; m_wd = d_wd;
      if (ir && m_streak < 7) m_streak++;
    end else if (ir) begin
      m_own = 1; m_addr = i_ad; m_wr = 0; m_wd = '0;
      m_streak = 0;
    end
  endtask

  task automatic clear_inputs();
    i_rd = 0; i_ad = '0; d_rd = 0; d_wr = 0;
    d_ad = '0; d_wd = '0; p_resp = 0; p_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 0;
    clear_inputs();
    @(negedge clk);
    reset_n = 1;
    m_clear();
  endtask

  logic [15:0] sx [3];
  bit got_i;
  bit got_d;
  logic eir;
  logic edr;

  initial begin : main
    reset_n = 0;
    clear_inputs();
    fill_table();

    // reset state
    repeat (2) @(negedge clk);
    p_rdata = R;
    #1;
    chk1("rst_read", pmem_read, 0);
    chk1("rst_write", pmem_write, 0);
    chk16("rst_addr", pmem_address, '0);
    chk128("rst_irdata", ic_rdata, '0);
    chk1("rst_ld", ld_regs, 0);
    @(negedge clk);
    reset_n = 1;
    #1;
    chk1("rel_ld", ld_regs, 1);

    // table
    d_wd = W;
    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      i_rd = vt[k].ir; i_ad = vt[k].ia;
      d_rd = vt[k].dr; d_wr = vt[k].dw;
      d_ad = vt[k].da; p_resp = vt[k].pr;
      #1;
      chk1($sformatf("v%0d_rd", k), pmem_read, vt[k].erd);
      chk1($sformatf("v%0d_wr", k), pmem_write, vt[k].ewr);
      chk16($sformatf("v%0d_addr", k), pmem_address,
            vt[k].eaddr);
      chk128($sformatf("v%0d_wd", k), pmem_wdata, vt[k].ewd);
      chk1($sformatf("v%0d_iresp", k), ic_resp, vt[k].eir);
      chk1($sformatf("v%0d_dresp", k), dc_resp, vt[k].edr);
      chk1($sformatf("v%0d_ld", k), ld_regs, vt[k].eld);
      chk128($sformatf("v%0d_irdata", k), ic_rdata, R);
      chk128($sformatf("v%0d_drdata", k), dc_rdata, R);
    end

    // starvation: dcache continuous, icache pending
    do_reset();
`ifdef PMEM_SCHED_STARVE_EN
    sx[0] = 16'hD000; sx[1] = 16'hD000; sx[2] = 16'h1000;
`else
    sx[0] = 16'hD000; sx[1] = 16'hD000; sx[2] = 16'hD000;
`endif
    @(negedge clk);
    d_rd = 1; d_ad = 16'hD000;
    i_rd = 1; i_ad = 16'h1000;
    #1;
    for (int k = 0; k < 3; k++) begin
      int n;
      n = 0;
      while (!pmem_read && n < 6) begin
        @(negedge clk);
        #1;
        n++;
      end
      chk1($sformatf("starve%0d_wait", k), n < 6, 1);
      chk16($sformatf("starve%0d_addr", k), pmem_address, sx[k]);
      @(negedge clk);
      p_resp = 1;
      @(negedge clk);
      p_resp = 0;
      #1;
    end
    i_rd = 0;
    d_rd = 0;
    repeat (2) @(negedge clk);

    // reset during GRANT_D before pmem_resp
    @(negedge clk);
    d_wr = 1; d_ad = 16'h8000; d_wd = W;
    @(negedge clk);
    #1;
    chk1("mid_pre_wr", pmem_write, 1);
    p_resp = 1; p_rdata = R;
    #2;
    reset_n = 0;
    #1;
    chk1("mid_read", pmem_read, 0);
    chk1("mid_write", pmem_write, 0);
    chk16("mid_addr", pmem_address, '0);
    chk128("mid_wdata", pmem_wdata, '0);
    chk1("mid_iresp", ic_resp, 0);
    chk1("mid_dresp", dc_resp, 0);
    chk128("mid_irdata", ic_rdata, '0);
    chk128("mid_drdata", dc_rdata, '0);
    chk1("mid_ld", ld_regs, 0);
    @(negedge clk);
    d_wr = 0; p_resp = 0;
    reset_n = 1;
    #1;
    chk1("post_ld", ld_regs, 1);
    chk1("post_write", pmem_write, 0);
    @(negedge clk);
    d_rd = 1; d_ad = 16'h0ABC;
    @(negedge clk);
    #1;
    chk1("post_read", pmem_read, 1);
    chk16("post_addr", pmem_address, 16'h0ABC);
    @(negedge clk);
    p_resp = 1;
    #1;
    chk1("post_dresp", dc_resp, 1);
    @(negedge clk);
    p_resp = 0; d_rd = 0;

    // randomized traffic vs model
    do_reset();
    got_i = 0;
    got_d = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (i_rd && (got_i || $urandom_range(0, 19) == 0))
        i_rd = 0;
      else if (!i_rd && $urandom_range(0, 2) == 0) begin
        i_rd = 1;
        i_ad = 16'($urandom);
      end
      if ((d_rd || d_wr) &&
          (got_d || $urandom_range(0, 19) == 0)) begin
        d_rd = 0;
        d_wr = 0;
      end else if (!(d_rd || d_wr) &&
                   $urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 2))
          0:       begin d_rd = 1; d_wr = 0; end
          1:       begin d_rd = 0; d_wr = 1; end
          default: begin d_rd = 1; d_wr = 1; end
        endcase
        d_ad = 16'($urandom);
        d_wd = {$urandom, $urandom, $urandom, $urandom};
      end
      p_resp = (m_own != 0) && ($urandom_range(0, 2) == 0);
      p_rdata = {$urandom, $urandom, $urandom, $urandom};
      #1;
      eir = (m_own == 1) && p_resp && i_rd;
      edr = (m_own == 2) && p_resp && (d_rd || d_wr);
      chk1("rnd_rd", pmem_read, (m_own != 0) && !m_wr);
      chk1("rnd_wr", pmem_write, (m_own != 0) && m_wr);
      chk16("rnd_addr", pmem_address, m_addr);
      chk128("rnd_wd", pmem_wdata, m_wd);
      chk1("rnd_iresp", ic_resp, eir);
      chk1("rnd_dresp", dc_resp, edr);
      chk1("rnd_ld", ld_regs,
           (m_own == 0) && !i_rd && !d_rd && !d_wr);
      chk128("rnd_irdata", ic_rdata, p_rdata);
      chk128("rnd_drdata", dc_rdata, p_rdata);
      got_i = eir;
      got_d = edr;
      m_step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pmem_sched.md
PMEM_SCHED -- requirements
Module: pmem_sched

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, the number of consecutive dcache grants allowed while icache waits (range 1..7).
REQ-002 SHALL have port clk  in  1  system clock, rising edge.
REQ-003 SHALL have port reset_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port icache_pmem_read  in  1  icache line-fill request.
REQ-005 SHALL have port icache_pmem_address  in  16  icache line address.
REQ-006 SHALL have port dcache_pmem_read  in  1  dcache line-fill request.
REQ-007 SHALL have port dcache_pmem_write  in  1  dcache write-back request.
REQ-008 SHALL have port dcache_pmem_address  in  16  dcache line address.
REQ-009 SHALL have port dcache_pmem_wdata  in  128  dcache write-back line.
REQ-010 SHALL have port pmem_resp  in  1  physical memory done.
REQ-011 SHALL have port pmem_rdata  in  128  physical memory read line.
REQ-012 SHALL have ports pmem_read, pmem_write  out  1 each  physical memory strobes.
REQ-013 SHALL have ports pmem_address  out  16 and pmem_wdata  out  128  physical memory command.
REQ-014 SHALL have ports icache_pmem_resp, dcache_pmem_resp  out  1 each  per-cache completion.
REQ-015 SHALL have ports icache_pmem_rdata, dcache_pmem_rdata  out  128 each  per-cache read line.
REQ-016 SHALL have port ld_regs  out  1  pipeline-latch advance enable.

Function
REQ-017 SHALL implement FSM states IDLE, GRANT_I, GRANT_D, DONE.
REQ-018 In IDLE, a dcache request (read or write) with no starvation condition SHALL move to GRANT_D; otherwise an icache request SHALL move to GRANT_I; no request SHALL stay in IDLE.
REQ-019 On entry to a GRANT state the granted address, op (read/write) and wdata SHALL be latched; pmem outputs SHALL come only from latched values, asserted the cycle after the grant decision.
REQ-020 dcache_pmem_read and dcache_pmem_write both high SHALL be resolved as a write.
REQ-021 In a GRANT state the strobe SHALL stay high until pmem_resp; on the pmem_resp cycle the granted cache's resp SHALL be asserted combinationally for exactly that cycle and the FSM SHALL go to DONE.
REQ-022 pmem_rdata SHALL be routed unregistered to both rdata outputs; only the granted resp is asserted.
REQ-023 A request dropped mid-grant SHALL still complete to pmem_resp; the cache resp SHALL be suppressed in that case.
REQ-024 DONE SHALL last one cycle with all pmem strobes low, then return to IDLE (turnaround so the served cache drops its request).
REQ-025 ld_regs SHALL be 1 when state is IDLE or DONE and no cache request is asserted; 0 otherwise.
REQ-026 Maximum latency from request to first pmem strobe SHALL be 2 cycles when idle.

Reset
REQ-027 reset_n low SHALL force IDLE, clear latches and the starvation counter, and drive every output to 0 immediately, including mid-transaction; ld_regs SHALL read 1 once reset deasserts with no requests pending.

Configuration
REQ-028 With PMEM_SCHED_STARVE_EN defined, a 3-bit saturating counter SHALL increment on each GRANT_D entered while icache_pmem_read is high, clear on GRANT_I, and when equal to STARVE_LIMIT force the next IDLE decision to GRANT_I.
REQ-029 Without PMEM_SCHED_STARVE_EN, dcache SHALL have strict priority and no counter SHALL exist.

Structure
REQ-030 State enum, 16-bit word and 128-bit line types SHALL live in lc3b_types; no sub-module required, the optional counter MAY be sub-module pmem_starve_ctr.

Verification
REQ-031 Icache read only, addr 0x1230, pmem_resp after 3 cycles -> pmem_read=1 with address 0x1230, icache_pmem_resp one cycle, rdata routed, ld_regs 0 throughout.
REQ-032 Icache and dcache read simultaneously -> GRANT_D first (address from dcache), then GRANT_I after DONE.
REQ-033 Dcache write, addr 0x8000, wdata pattern 0xA5.. -> pmem_write=1, pmem_wdata matches, dcache_pmem_resp on pmem_resp.
REQ-034 STARVE_EN, STARVE_LIMIT=2, dcache requesting continuously with icache pending -> two D grants then one I grant.
REQ-035 Reset_n low during GRANT_D before pmem_resp -> all outputs 0 same cycle, IDLE after release.
REQ-036 Icache drops request mid-grant -> pmem completes, icache_pmem_resp stays 0, FSM returns to IDLE via DONE.
